// File: rtl/mem_xfer_ctrl.sv
// rtl/mem_xfer_ctrl.sv - block-transfer sequencer between the 2048x16 SRAM and the 32-entry register file
//
// Purpose: accepts one load (SRAM->RF) or store (RF->SRAM) command over a
// start/busy/done handshake and drives every datapath control, one word per
// cycle, followed by a bus turnaround cycle and a one-cycle done pulse.
//
// Ports:
//   clk, nRst           clock, synchronous active-low reset
//   start, cmdStore     command strobe (accepted only when idle), 1 = store
//   cmdSramAdrx         first SRAM word address
//   cmdRegIdx           first register index (binary)
//   cmdCount            words to move, clamped to 32
//   abort               ends the active command after the current word
//   busy, done          handshake status; done is a one-cycle pulse
//   wordsMoved          words moved by the last command
//   sramAdrx            SRAM address
//   sramNotOutEn        SRAM output enable, active low
//   sramRead            1 = read/idle, 0 = SRAM writes the bus at the edge
//   rfWriteAdrx         one-hot RF write address
//   rfRdAdrx1           one-hot RF read port 1 address (unused, tied to 0)
//   rfRdAdrx0           one-hot RF read port 0 address
//   rfWriteEn           RF write enable
//   dataMuxSel          bus driver select: 3 = rdRF0, 2 = rdRF1, 0 = Z
//
// Optional feature macro: MEM_XFER_VERIFY_EN
//   Adds a VERIFY pass after each store that re-reads the stored range and
//   compares the bus with rdRF0 (inputs busData, rfRd0Data), flagging any
//   mismatch on output verifyErr.
module mem_xfer_ctrl #(
  parameter int SRAM_AW = 11,
  parameter int NREG    = 32,
  parameter int RIDX_W  = 5
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               start,
  input  logic               cmdStore,
  input  logic [SRAM_AW-1:0] cmdSramAdrx,
  input  logic [RIDX_W-1:0]  cmdRegIdx,
  input  logic [5:0]         cmdCount,
  input  logic               abort,
`ifdef MEM_XFER_VERIFY_EN
  input  logic [15:0]        busData,
  input  logic [15:0]        rfRd0Data,
  output logic               verifyErr,
`endif
  output logic               busy,
  output logic               done,
  output logic [5:0]         wordsMoved,
  output logic [SRAM_AW-1:0] sramAdrx,
  output logic               sramNotOutEn,
  output logic               sramRead,
  output logic [NREG-1:0]    rfWriteAdrx,
  output logic [NREG-1:0]    rfRdAdrx1,
  output logic [NREG-1:0]    rfRdAdrx0,
  output logic               rfWriteEn,
  output logic [1:0]         dataMuxSel
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STORE, S_TURN, S_DONE
`ifdef MEM_XFER_VERIFY_EN
    , S_VERIFY
`endif
  } state_t;

  state_t             state;
  logic [SRAM_AW-1:0] adrx;      // address of the next word to issue
  logic [RIDX_W-1:0]  idx;       // register index of the next word to issue
  logic [5:0]         lim;
  logic [5:0]         counter;
  logic [5:0]         clamped;
  logic               xfer_end;

  logic               iss_go;
  logic               iss_store;
  logic [SRAM_AW-1:0] iss_adrx;
  logic [RIDX_W-1:0]  iss_idx;

`ifdef MEM_XFER_VERIFY_EN
  logic [SRAM_AW-1:0] start_adrx;
  logic [RIDX_W-1:0]  start_idx;
  logic [5:0]         vcnt;
`endif

  function automatic logic [NREG-1:0] onehot(input logic [RIDX_W-1:0] i);
    logic [NREG-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign clamped   = (cmdCount > 6'd32) ? 6'd32 : cmdCount;
  // The word in flight this cycle is the last one, or we were told to stop.
  assign xfer_end  = ((counter + 6'd1) == lim) || abort;
  assign rfRdAdrx1 = '0;

  // Selects which word (if any) the registered datapath controls present next
  // cycle: the first word on acceptance, or the following word mid-transfer.
  always_comb begin
    iss_go    = 1'b0;
    iss_store = cmdStore;
    iss_adrx  = cmdSramAdrx;
    iss_idx   = cmdRegIdx;
    case (state)
      S_IDLE: iss_go = start && (clamped != 6'd0);
      S_LOAD, S_STORE: begin
        iss_go    = !xfer_end;
        iss_store = (state == S_STORE);
        iss_adrx  = adrx;
        iss_idx   = idx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state        <= S_IDLE;
      adrx         <= '0;
      idx          <= '0;
      lim          <= '0;
      counter      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      wordsMoved   <= '0;
      sramAdrx     <= '0;
      sramNotOutEn <= 1'b1;
      sramRead     <= 1'b1;
      rfWriteAdrx  <= '0;
      rfRdAdrx0    <= '0;
      rfWriteEn    <= 1'b0;
      dataMuxSel   <= 2'd0;
`ifdef MEM_XFER_VERIFY_EN
      start_adrx   <= '0;
      start_idx    <= '0;
      vcnt         <= '0;
      verifyErr    <= 1'b0;
`endif
    end else begin
      // Datapath controls fall back to idle unless a word is issued below,
      // which also gives the turnaround cycle its released bus.
      done         <= 1'b0;
      sramAdrx     <= '0;
      sramNotOutEn <= 1'b1;
      sramRead     <= 1'b1;
      rfWriteAdrx  <= '0;
      rfRdAdrx0    <= '0;
      rfWriteEn    <= 1'b0;
      dataMuxSel   <= 2'd0;

      case (state)
        S_IDLE: begin
          if (start) begin
            lim        <= clamped;
            counter    <= '0;
            wordsMoved <= '0;
            busy       <= 1'b1;
`ifdef MEM_XFER_VERIFY_EN
            start_adrx <= cmdSramAdrx;
            start_idx  <= cmdRegIdx;
            verifyErr  <= 1'b0;
`endif
            if (clamped == 6'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= cmdStore ? S_STORE : S_LOAD;
            end
          end
        end
        S_LOAD, S_STORE: begin
          counter <= counter + 6'd1;
          if (xfer_end) begin
`ifdef MEM_XFER_VERIFY_EN
            if (state == S_STORE) begin
              state        <= S_VERIFY;
              vcnt         <= '0;
              sramAdrx     <= start_adrx;
              sramNotOutEn <= 1'b0;
              rfRdAdrx0    <= onehot(start_idx);
              adrx         <= start_adrx + SRAM_AW'(1);
              idx          <= start_idx + RIDX_W'(1);
            end else
`endif
            state <= S_TURN;
          end
        end
`ifdef MEM_XFER_VERIFY_EN
        S_VERIFY: begin
          if (busData != rfRd0Data) verifyErr <= 1'b1;
          vcnt <= vcnt + 6'd1;
          if ((vcnt + 6'd1) == counter) begin
            state <= S_TURN;
          end else begin
            sramAdrx     <= adrx;
            sramNotOutEn <= 1'b0;
            rfRdAdrx0    <= onehot(idx);
            adrx         <= adrx + SRAM_AW'(1);
            idx          <= idx + RIDX_W'(1);
          end
        end
`endif
        S_TURN: begin
          state      <= S_DONE;
          done       <= 1'b1;
          wordsMoved <= counter;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      if (iss_go) begin
        sramAdrx <= iss_adrx;
        adrx     <= iss_adrx + SRAM_AW'(1);
        idx      <= iss_idx + RIDX_W'(1);
        if (iss_store) begin
          rfRdAdrx0  <= onehot(iss_idx);
          dataMuxSel <= 2'd3;
          sramRead   <= 1'b0;
        end else begin
          rfWriteAdrx  <= onehot(iss_idx);
          rfWriteEn    <= 1'b1;
          sramNotOutEn <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// tb/tb_mem_xfer_ctrl.sv - self-checking bench for mem_xfer_ctrl with SRAM and register-file models
module tb_mem_xfer_ctrl;

  logic        clk = 1'b0;
  logic        nRst;
  logic        start;
  logic        cmdStore;
  logic [10:0] cmdSramAdrx;
  logic [4:0]  cmdRegIdx;
  logic [5:0]  cmdCount;
  logic        abort;
  logic        busy;
  logic        done;
  logic [5:0]  wordsMoved;
  logic [10:0] sramAdrx;
  logic        sramNotOutEn;
  logic        sramRead;
  logic [31:0] rfWriteAdrx;
  logic [31:0] rfRdAdrx1;
  logic [31:0] rfRdAdrx0;
  logic        rfWriteEn;
  logic [1:0]  dataMuxSel;

  always #5 clk = ~clk;

  mem_xfer_ctrl dut (
    .clk(clk), .nRst(nRst), .start(start), .cmdStore(cmdStore),
    .cmdSramAdrx(cmdSramAdrx), .cmdRegIdx(cmdRegIdx), .cmdCount(cmdCount),
    .abort(abort), .busy(busy), .done(done), .wordsMoved(wordsMoved),
    .sramAdrx(sramAdrx), .sramNotOutEn(sramNotOutEn), .sramRead(sramRead),
    .rfWriteAdrx(rfWriteAdrx), .rfRdAdrx1(rfRdAdrx1), .rfRdAdrx0(rfRdAdrx0),
    .rfWriteEn(rfWriteEn), .dataMuxSel(dataMuxSel)
  );

  logic [15:0] sram [0:2047];
  logic [15:0] rf   [0:31];
  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int done_seen = 0;

  typedef struct {
    bit              store;
    int              adrx;
    int              idx;
    int              cnt;
    int              words;
    int              lat;
    bit              chk_rf;
    int              nchk;
    logic [3:0][15:0] v;
    int              inj;
  } vec_t;

  function automatic int oh2idx(input logic [31:0] oh);
    int r = 0;
    for (int i = 0; i < 32; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: sample the datapath mid-cycle, model the SRAM/RF edge writes,
  // then return 1 time unit after the rising edge.
  task automatic tick();
    logic [15:0] bus;
    logic        wr_rf, wr_sram;
    int          ri;
    logic [10:0] sa;
    @(negedge clk);
    checks++;
    if ((!sramNotOutEn && dataMuxSel != 2'd0) || (rfWriteEn && !sramRead)) begin
      errors++;
      $display("FAIL bus_conflict: nOE=%0b mux=%0d wen=%0b read=%0b", sramNotOutEn, dataMuxSel, rfWriteEn, sramRead);
    end
    if (!sramNotOutEn || !sramRead || rfWriteEn) acc_cnt++;
    if (done) done_seen++;
    if (!sramNotOutEn && sramRead) bus = sram[sramAdrx];
    else if (dataMuxSel == 2'd3)   bus = rf[oh2idx(rfRdAdrx0)];
    else                           bus = 16'hDEAD;
    wr_rf   = rfWriteEn;
    wr_sram = !sramRead;
    ri      = oh2idx(rfWriteAdrx);
    sa      = sramAdrx;
    @(posedge clk);
    if (wr_rf)   rf[ri]   = bus;
    if (wr_sram) sram[sa] = bus;
    #1;
  endtask

  initial begin
    vec_t vecs [0:5];
    int   lat;
    int   act;

    vecs[0] = '{1'b0, 'h100, 4,  4,  4, 6,  1'b1, 4, {16'h00A4, 16'h00A3, 16'h00A2, 16'h00A1}, -1};
    vecs[1] = '{1'b1, 'h7FF, 30, 3,  3, 5,  1'b0, 3, {16'h0000, 16'h0077, 16'h0066, 16'h0055}, -1};
    vecs[2] = '{1'b0, 'h500, 9,  0,  0, 1,  1'b1, 1, {16'h0000, 16'h0000, 16'h0000, 16'h0999}, -1};
    vecs[3] = '{1'b0, 'h200, 28, 40, 32, 34, 1'b1, 4, {16'h1003, 16'h1002, 16'h1001, 16'h1000}, -1};
    vecs[4] = '{1'b1, 'h300, 8,  1,  1, 3,  1'b0, 2, {16'h0000, 16'h0000, 16'h0BAD, 16'h100C}, -1};
    vecs[5] = '{1'b0, 'h100, 4,  4,  4, 6,  1'b1, 4, {16'h00A4, 16'h00A3, 16'h00A2, 16'h00A1}, 2};

    for (int k = 0; k < 2048; k++) sram[k] = 16'h0000;
    for (int k = 0; k < 32; k++)   rf[k]   = 16'h0000;
    for (int k = 0; k < 4; k++)    sram['h100 + k] = 16'(16'hA1 + k);
    for (int k = 0; k < 32; k++)   sram['h200 + k] = 16'(16'h1000 + k);
    sram['h500] = 16'h1234;
    sram['h301] = 16'h0BAD;
    rf[30] = 16'h0055;
    rf[31] = 16'h0066;
    rf[0]  = 16'h0077;
    rf[9]  = 16'h0999;

    nRst = 1'b0; start = 1'b0; cmdStore = 1'b0; cmdSramAdrx = '0;
    cmdRegIdx = '0; cmdCount = '0; abort = 1'b0;

    tick();
    check("rst_busy",   int'(busy), 0);
    check("rst_done",   int'(done), 0);
    check("rst_read",   int'(sramRead), 1);
    check("rst_noe",    int'(sramNotOutEn), 1);
    check("rst_mux",    int'(dataMuxSel), 0);
    check("rst_wen",    int'(rfWriteEn), 0);
    check("rst_rd1",    int'(rfRdAdrx1), 0);
    check("rst_words",  int'(wordsMoved), 0);
    tick();
    nRst = 1'b1;
    tick();

    for (int r = 0; r < 6; r++) begin
      start       = 1'b1;
      cmdStore    = vecs[r].store;
      cmdSramAdrx = 11'(vecs[r].adrx);
      cmdRegIdx   = 5'(vecs[r].idx);
      cmdCount    = 6'(vecs[r].cnt);
      tick();
      start   = 1'b0;
      acc_cnt = 0;
      lat     = 1;
      while (!done && lat < 100) begin
        if (lat == vecs[r].inj) begin
          start       = 1'b1;
          cmdStore    = !vecs[r].store;
          cmdSramAdrx = 11'h000;
          cmdCount    = 6'd2;
        end
        tick();
        start = 1'b0;
        lat++;
      end
      check($sformatf("v%0d_latency", r), lat, vecs[r].lat);
      check($sformatf("v%0d_words", r), int'(wordsMoved), vecs[r].words);
      check($sformatf("v%0d_accesses", r), acc_cnt, vecs[r].words);
      for (int k = 0; k < vecs[r].nchk; k++) begin
        if (vecs[r].chk_rf) act = int'(rf[(vecs[r].idx + k) % 32]);
        else                act = int'(sram[(vecs[r].adrx + k) % 2048]);
        check($sformatf("v%0d_data%0d", r, k), act, int'(vecs[r].v[k]));
      end
      tick();
      check($sformatf("v%0d_done_pulse", r), int'(done), 0);
      check($sformatf("v%0d_idle", r), int'(busy), 0);
    end

    // Abort during the third store cycle: three words land, then TURN, then done.
    for (int k = 0; k < 10; k++) begin
      rf[10 + k]      = 16'(16'hB0 + k);
      sram['h400 + k] = 16'h0000;
    end
    start = 1'b1; cmdStore = 1'b1; cmdSramAdrx = 11'h400; cmdRegIdx = 5'd10; cmdCount = 6'd10;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_turn_busy", int'(busy), 1);
    check("abort_turn_done", int'(done), 0);
    check("abort_turn_read", int'(sramRead), 1);
    check("abort_turn_mux",  int'(dataMuxSel), 0);
    tick();
    check("abort_done",      int'(done), 1);
    check("abort_words",     int'(wordsMoved), 3);
    check("abort_last_word", int'(sram['h402]), 'hB2);
    check("abort_no_4th",    int'(sram['h403]), 0);
    tick();
    check("abort_idle", int'(busy), 0);

    // Reset in the middle of a load discards it without a done pulse.
    done_seen = 0;
    start = 1'b1; cmdStore = 1'b0; cmdSramAdrx = 11'h200; cmdRegIdx = 5'd20; cmdCount = 6'd8;
    tick();
    start = 1'b0;
    tick();
    tick();
    nRst = 1'b0;
    tick();
    check("midrst_busy",  int'(busy), 0);
    check("midrst_noe",   int'(sramNotOutEn), 1);
    check("midrst_wen",   int'(rfWriteEn), 0);
    check("midrst_wadr",  int'(rfWriteAdrx), 0);
    check("midrst_sadr",  int'(sramAdrx), 0);
    check("midrst_words", int'(wordsMoved), 0);
    nRst = 1'b1;
    repeat (12) tick();
    check("midrst_no_done", done_seen, 0);
    check("midrst_idle", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
